lab2_proc_muldiv_iter: RTL and testbench
========================================

Name: lab2_proc_muldiv_iter

Overview:
- Parametrised iterative integer multiply/divide unit for the processor's X stage; successor to the single-cycle ALU.
- Covers all eight RV32M operations at configurable width, one bit per cycle.
- Decoupled val/rdy request/response interfaces; the pipeline stalls while the unit is busy.
- One operation in flight at a time.

Parameters:
- p_nbits, 32, operand/result width; legal range 4..64.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req_val  input  1  request valid
- req_rdy  output  1  unit can accept a request
- req_fn  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- req_op0  input  p_nbits  rs1 operand (multiplicand / dividend)
- req_op1  input  p_nbits  rs2 operand (multiplier / divisor)
- resp_val  output  1  result valid
- resp_rdy  input  1  consumer accepts result
- resp_result  output  p_nbits  result
- busy  output  1  high in CALC or DONE

Behaviour:
- Reset (async, immediate):
  - state=IDLE; req_rdy=1; resp_val=0; resp_result=0; busy=0.
  - All internal registers cleared.
  - Reset mid-operation aborts the operation; no response is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - req_rdy=1.
  - On req_val&&req_rdy: latch fn; latch operand magnitudes; latch result sign.
  - Result sign rules:
    - MUL/MULH: op0 sign XOR op1 sign.
    - MULHSU: op0 sign only.
    - DIV: quotient sign = op0 sign XOR op1 sign.
    - REM: remainder sign = op0 sign.
    - Unsigned ops: positive.
  - Special case → DONE directly (next cycle, no CALC):
    - op1==0 on any divide/remainder:
      - DIV/DIVU: result = all ones.
      - REM/REMU: result = op0.
    - DIV/REM with op0 = -2^(p_nbits-1) and op1 = all ones (−1):
      - DIV: result = op0.
      - REM: result = 0.
  - Otherwise → CALC with counter = p_nbits.
- CALC (exactly p_nbits cycles; req_rdy=0):
  - Multiply: shift-add on magnitudes into a 2*p_nbits product register; multiplier shifted right, multiplicand shifted left each cycle.
  - Divide: restoring; remainder/quotient register pair shifted left 1 bit per cycle; subtract divisor if no borrow, setting quotient LSB.
  - Counter decrements each cycle; at counter==1, next state is DONE.
- Result formation, in the CALC→DONE transition edge:
  - Apply two's-complement negation to the full product or to the quotient/remainder when the latched sign requires it.
  - Result selection:
    - MUL: low p_nbits of product.
    - MULH/MULHSU/MULHU: high p_nbits of product.
    - DIV*: quotient.
    - REM*: remainder.
- DONE:
  - resp_val=1; resp_result stable until handshake.
  - resp_val&&resp_rdy → IDLE.
  - resp_val and resp_result do not change while resp_rdy=0 (backpressure of any length).
  - req_rdy=0 in DONE; no same-cycle new accept on response handshake.
- Latency, accept at edge t:
  - Normal ops: resp_val first high in cycle t+p_nbits+1.
  - Special cases: resp_val high in cycle t+1.
  - Throughput: at most one op per p_nbits+2 cycles.
- req_fn, req_op0 and req_op1 are don't-care when req_val=0 or req_rdy=0. Inputs are not sampled after the accept edge.
- Width rules:
  - Internal product register is 2*p_nbits bits.
  - Remainder register is p_nbits+1 bits (carries the borrow).
  - No X may propagate to resp_result for any defined req_fn.

Test Plan:
- p_nbits=32, MUL 0xFFFFFFFD (-3) × 7 → 0xFFFFFFEB; resp_val exactly 33 cycles after accept; req_rdy=0 throughout.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases, each with resp_val 1 cycle after accept:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- Backpressure and reset:
  - Hold resp_rdy=0 for 10 cycles → resp_result stable and req_rdy=0; then resp_rdy=1 → IDLE next cycle.
  - Assert reset mid-CALC → req_rdy=1 and resp_val=0 immediately.
- p_nbits=8 instance: MUL 0x0F × 0x11 → 0xFF; DIVU 0xFF/0x10 → 0x0F; latency 9 cycles.

Source files
------------

// File: rtl/lab2_proc_muldiv_iter.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, val/rdy request and response.
// Shift-add multiply on magnitudes, restoring divide, sign fixed up on the final step.
module lab2_proc_muldiv_iter #(
  parameter int unsigned p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [2:0]         req_fn,
  input  logic [p_nbits-1:0] req_op0,
  input  logic [p_nbits-1:0] req_op1,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [p_nbits-1:0] resp_result,
  output logic               busy
);

  localparam int unsigned CntW = $clog2(p_nbits + 1);
  localparam logic [p_nbits-1:0] MinVal = {1'b1, {(p_nbits-1){1'b0}}};

  localparam logic [2:0] FnMul    = 3'd0;
  localparam logic [2:0] FnMulh   = 3'd1;
  localparam logic [2:0] FnMulhsu = 3'd2;
  localparam logic [2:0] FnDiv    = 3'd4;
  localparam logic [2:0] FnRem    = 3'd6;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             fn_q, fn_d;
  logic                   neg_q, neg_d;
  logic [2*p_nbits-1:0]   mcand_q, mcand_d;
  logic [p_nbits-1:0]     mplier_q, mplier_d;
  logic [2*p_nbits-1:0]   prod_q, prod_d;
  logic [p_nbits-1:0]     divisor_q, divisor_d;
  logic [p_nbits:0]       rem_q, rem_d;
  logic [p_nbits-1:0]     quo_q, quo_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [p_nbits-1:0]     result_q, result_d;

  // Request decode
  logic                   op0_signed, op1_signed, s0, s1, in_neg, div_zero, div_ovf;
  logic [p_nbits-1:0]     mag0, mag1;

  always_comb begin
    op0_signed = (req_fn == FnMul) || (req_fn == FnMulh) || (req_fn == FnMulhsu) ||
                 (req_fn == FnDiv) || (req_fn == FnRem);
    op1_signed = (req_fn == FnMul) || (req_fn == FnMulh) ||
                 (req_fn == FnDiv) || (req_fn == FnRem);
    s0         = op0_signed & req_op0[p_nbits-1];
    s1         = op1_signed & req_op1[p_nbits-1];
    mag0       = s0 ? -req_op0 : req_op0;
    mag1       = s1 ? -req_op1 : req_op1;
    // Remainder takes the dividend's sign; everything else the XOR of both.
    in_neg     = s0 ^ (s1 & (req_fn != FnRem));
    div_zero   = req_fn[2] && (req_op1 == '0);
    div_ovf    = ((req_fn == FnDiv) || (req_fn == FnRem)) &&
                 (req_op0 == MinVal) && (req_op1 == '1);
  end

  // One iteration of both datapaths
  logic [2*p_nbits-1:0]   prod_step, prod_fix;
  logic [p_nbits:0]       rem_shift, rem_step;
  logic                   rem_ge;
  logic [p_nbits-1:0]     quo_step, quo_fix, rem_fix, final_res;

  always_comb begin
    prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    rem_shift = {rem_q[p_nbits-1:0], quo_q[p_nbits-1]};
    rem_ge    = rem_q[p_nbits] | (rem_shift >= {1'b0, divisor_q});
    rem_step  = rem_ge ? (rem_shift - {1'b0, divisor_q}) : rem_shift;
    quo_step  = {quo_q[p_nbits-2:0], rem_ge};
    prod_fix  = neg_q ? -prod_step : prod_step;
    quo_fix   = neg_q ? -quo_step : quo_step;
    rem_fix   = neg_q ? -rem_step[p_nbits-1:0] : rem_step[p_nbits-1:0];
    final_res = rem_fix;
    case (fn_q)
      3'd0:             final_res = prod_fix[p_nbits-1:0];
      3'd1, 3'd2, 3'd3: final_res = prod_fix[2*p_nbits-1:p_nbits];
      3'd4, 3'd5:       final_res = quo_fix;
      default:          final_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    fn_d      = fn_q;
    neg_d     = neg_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    unique case (state_q)
      StIdle: begin
        if (req_val) begin
          fn_d      = req_fn;
          neg_d     = in_neg;
          mcand_d   = {{p_nbits{1'b0}}, mag0};
          mplier_d  = mag1;
          prod_d    = '0;
          divisor_d = mag1;
          rem_d     = '0;
          quo_d     = mag0;
          if (div_zero) begin
            result_d = req_fn[1] ? req_op0 : '1;
            state_d  = StDone;
          end else if (div_ovf) begin
            result_d = req_fn[1] ? '0 : req_op0;
            state_d  = StDone;
          end else begin
            cnt_d   = CntW'(p_nbits);
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        rem_d    = rem_step;
        quo_d    = quo_step;
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          result_d = final_res;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (resp_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      fn_q      <= '0;
      neg_q     <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      fn_q      <= fn_d;
      neg_q     <= neg_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  assign req_rdy     = (state_q == StIdle);
  assign resp_val    = (state_q == StDone);
  assign busy        = (state_q != StIdle);
  assign resp_result = result_q;

endmodule

// File: tb/tb_lab2_proc_muldiv_iter.sv
// Bench for lab2_proc_muldiv_iter: 32-bit and 8-bit instances, vector table plus random ops
// against a behavioural model, scoreboard of expected results, reset and backpressure corners.
module tb_lab2_proc_muldiv_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_val, resp_rdy, sel8;
  logic [2:0]  req_fn;
  logic [31:0] req_op0, req_op1;

  logic        req_val32, req_rdy32, resp_val32, busy32;
  logic [31:0] result32;
  logic        req_val8, req_rdy8, resp_val8, busy8;
  logic [7:0]  result8;

  logic        o_req_rdy, o_resp_val, o_busy;
  logic [31:0] o_result;

  assign req_val32 = req_val & ~sel8;
  assign req_val8  = req_val & sel8;

  always_comb begin
    o_req_rdy  = sel8 ? req_rdy8 : req_rdy32;
    o_resp_val = sel8 ? resp_val8 : resp_val32;
    o_busy     = sel8 ? busy8 : busy32;
    o_result   = sel8 ? {24'b0, result8} : result32;
  end

  lab2_proc_muldiv_iter #(.p_nbits(32)) dut32 (
    .clk(clk), .reset(reset), .req_val(req_val32), .req_rdy(req_rdy32), .req_fn(req_fn),
    .req_op0(req_op0), .req_op1(req_op1), .resp_val(resp_val32), .resp_rdy(resp_rdy),
    .resp_result(result32), .busy(busy32)
  );

  lab2_proc_muldiv_iter #(.p_nbits(8)) dut8 (
    .clk(clk), .reset(reset), .req_val(req_val8), .req_rdy(req_rdy8), .req_fn(req_fn),
    .req_op0(req_op0[7:0]), .req_op1(req_op1[7:0]), .resp_val(resp_val8), .resp_rdy(resp_rdy),
    .resp_result(result8), .busy(busy8)
  );

  typedef struct {
    bit          w8;
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] result;
    int          lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cur_op = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (op %0d): got %0h, expected %0h", nm, cur_op, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit w8, input logic [2:0] fn, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] e, input int lat,
                              input int hold);
    vec_t v;
    v.w8 = w8; v.fn = fn; v.a = a; v.b = b; v.exp = e; v.lat = lat; v.hold = hold;
    return v;
  endfunction

  // Behavioural reference for the 32-bit instance
  function automatic logic [31:0] model(input logic [2:0] fn, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0]        p;
    logic signed [63:0] sa, sb_, sp;
    logic signed [31:0] a32, b32;
    logic               ovf;
    a32 = a;
    b32 = b;
    sa  = {{32{a[31]}}, a};
    ovf = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
    model = '0;
    case (fn)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; model = p[31:0]; end
      3'd1: begin sb_ = {{32{b[31]}}, b}; sp = sa * sb_; model = sp[63:32]; end
      3'd2: begin sb_ = {32'b0, b}; sp = sa * sb_; model = sp[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; model = p[63:32]; end
      3'd4: model = (b == 0) ? 32'hffff_ffff : ovf ? a : 32'(a32 / b32);
      3'd5: model = (b == 0) ? 32'hffff_ffff : a / b;
      3'd6: model = (b == 0) ? a : ovf ? 32'h0 : 32'(a32 % b32);
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input vec_t v);
    exp_t        e;
    int          lat;
    bit          rdy_bad, hold_bad;
    logic [31:0] saved;
    sel8 = v.w8;
    #1;
    chk("req_rdy_idle", 64'(o_req_rdy), 64'(1));
    req_val = 1'b1;
    req_fn  = v.fn;
    req_op0 = v.a;
    req_op1 = v.b;
    sb.push_back('{result: v.exp, lat: v.lat});
    @(posedge clk);
    #1;
    req_val = 1'b0;
    req_fn  = 3'($urandom);
    req_op0 = $urandom;
    req_op1 = $urandom;
    lat     = 1;
    rdy_bad = 1'b0;
    while (!o_resp_val && lat < 200) begin
      if (o_req_rdy || !o_busy) rdy_bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'(sb.size()), 64'(1));
      return;
    end
    e = sb.pop_front();
    chk("latency", 64'(lat), 64'(e.lat));
    chk("req_rdy_low_calc", 64'(rdy_bad), 64'(0));
    chk("result", 64'(o_result), 64'(e.result));
    saved    = o_result;
    hold_bad = 1'b0;
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk);
      #1;
      if (!o_resp_val || o_result !== saved || o_req_rdy || !o_busy) hold_bad = 1'b1;
    end
    if (v.hold > 0) chk("hold_stable", 64'(hold_bad), 64'(0));
    resp_rdy = 1'b1;
    @(posedge clk);
    #1;
    resp_rdy = 1'b0;
    chk("idle_after", 64'({o_req_rdy, o_resp_val, o_busy}), 64'(3'b100));
    cur_op++;
  endtask

  initial begin
    bit          stray;
    vec_t        v;
    logic [2:0]  fn;
    logic [31:0] a, b;
    bit          spec;

    reset = 1'b1; req_val = 1'b0; resp_rdy = 1'b0; sel8 = 1'b0;
    req_fn = '0; req_op0 = '0; req_op1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state32", 64'({req_rdy32, resp_val32, busy32, result32}), 64'({3'b100, 32'h0}));
    chk("reset_state8", 64'({req_rdy8, resp_val8, busy8, result8}), 64'({3'b100, 8'h0}));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);

    vecs.push_back(mk(0, 3'd0, 32'hffff_fffd, 32'd7, 32'hffff_ffeb, 33, 10));
    vecs.push_back(mk(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0));
    vecs.push_back(mk(0, 3'd3, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 33, 1));
    vecs.push_back(mk(0, 3'd2, 32'hffff_ffff, 32'd2, 32'hffff_ffff, 33, 0));
    vecs.push_back(mk(0, 3'd0, 32'h1234_5678, 32'd9, 32'ha3d7_0a38, 33, 0));
    vecs.push_back(mk(0, 3'd4, 32'hffff_fff9, 32'd2, 32'hffff_fffd, 33, 0));
    vecs.push_back(mk(0, 3'd6, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 33, 2));
    vecs.push_back(mk(0, 3'd5, 32'd100, 32'd7, 32'd14, 33, 0));
    vecs.push_back(mk(0, 3'd7, 32'd100, 32'd7, 32'd2, 33, 0));
    vecs.push_back(mk(0, 3'd4, 32'd7, 32'hffff_fffe, 32'hffff_fffd, 33, 0));
    vecs.push_back(mk(0, 3'd6, 32'd7, 32'hffff_fffe, 32'd1, 33, 0));
    vecs.push_back(mk(0, 3'd5, 32'd7, 32'd100, 32'd0, 33, 0));
    vecs.push_back(mk(0, 3'd4, 32'd5, 32'd0, 32'hffff_ffff, 1, 0));
    vecs.push_back(mk(0, 3'd7, 32'd5, 32'd0, 32'd5, 1, 3));
    vecs.push_back(mk(0, 3'd4, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 1, 0));
    vecs.push_back(mk(0, 3'd6, 32'h8000_0000, 32'hffff_ffff, 32'd0, 1, 0));
    vecs.push_back(mk(1, 3'd0, 32'h0f, 32'h11, 32'hff, 9, 0));
    vecs.push_back(mk(1, 3'd5, 32'hff, 32'h10, 32'h0f, 9, 2));
    vecs.push_back(mk(1, 3'd1, 32'h80, 32'h80, 32'h40, 9, 0));
    vecs.push_back(mk(1, 3'd4, 32'h80, 32'hff, 32'h80, 1, 0));
    vecs.push_back(mk(1, 3'd6, 32'hf9, 32'h02, 32'hff, 9, 0));

    for (int i = 0; i < 24; i++) begin
      fn   = 3'($urandom_range(0, 7));
      a    = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b    = ($urandom_range(0, 5) == 0) ? 32'h0 :
             ($urandom_range(0, 5) == 0) ? 32'hffff_ffff : $urandom >> $urandom_range(0, 31);
      spec = fn[2] && ((b == 0) || ((fn == 3'd4 || fn == 3'd6) &&
                                    a == 32'h8000_0000 && b == 32'hffff_ffff));
      vecs.push_back(mk(0, fn, a, b, model(fn, a, b), spec ? 1 : 33,
                        int'($urandom_range(0, 3))));
    end

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset in the middle of a calculation aborts it with no response
    sel8    = 1'b0;
    req_val = 1'b1;
    req_fn  = 3'd0;
    req_op0 = 32'd1234;
    req_op1 = 32'd5678;
    sb.push_back('{result: 32'd0, lat: 33});
    @(posedge clk);
    #1;
    req_val = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("reset_mid_calc", 64'({req_rdy32, resp_val32, busy32}), 64'(3'b100));
    if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    reset = 1'b0;
    stray = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (resp_val32 || !req_rdy32) stray = 1'b1;
    end
    chk("no_resp_after_abort", 64'(stray), 64'(0));
    cur_op++;
    run_op(mk(0, 3'd3, 32'd1234, 32'd5678, 32'd0, 33, 0));
    run_op(mk(0, 3'd0, 32'd1234, 32'd5678, 32'd7006652, 33, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
